// File: rtl/lz77_decoder_stream_if.sv
// Token and character stream channels of the LZ77 decoder.
// master = token source / character sink side, slave = decoder side.
interface lz77_decoder_stream_if #(
  parameter int DATA_W = 8,
  parameter int POS_W  = 5,
  parameter int LEN_W  = 5
);
  logic              tok_valid;
  logic              tok_ready;
  logic [POS_W-1:0]  tok_pos;
  logic [LEN_W-1:0]  tok_len;
  logic [DATA_W-1:0] tok_char;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_char;

  modport master (
    output tok_valid, tok_pos, tok_len, tok_char, out_ready,
    input  tok_ready, out_valid, out_char
  );

  modport slave (
    input  tok_valid, tok_pos, tok_len, tok_char, out_ready,
    output tok_ready, out_valid, out_char
  );
endinterface

// File: rtl/lz77_decoder_stream.sv
// Streaming LZ77 decoder: (position, length, literal) tokens in, one
// decoded character per cycle out, with a shift-register history window.
// Optional macro LZ77_POS_CHECK_EN adds a fill counter and a sticky err
// flag for tokens that reference characters not yet in the window.
module lz77_decoder_stream #(
  parameter int                DATA_W    = 8,
  parameter int                WIN_DEPTH = 30,
  parameter int                POS_W     = 5,
  parameter int                LEN_W     = 5,
  parameter logic [DATA_W-1:0] END_CHAR  = 8'h24
) (
  input  logic                    clk,
  input  logic                    reset,
  lz77_decoder_stream_if.slave    bus,
  output logic                    finish,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;

  localparam logic [POS_W:0] WIN_DEPTH_P = (POS_W+1)'(WIN_DEPTH);

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_win [WIN_DEPTH];
  logic [POS_W-1:0]  r_pos;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_char;

  logic              w_tok_ready;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_char;
  logic              w_finish;
  logic              w_tok_acc;
  logic              w_out_hs;
  logic [DATA_W-1:0] w_copy_char;

  assign w_tok_acc = bus.tok_valid & w_tok_ready;
  assign w_out_hs  = w_out_valid & bus.out_ready;

  // Positions beyond the window depth read as zero instead of indexing off the end
  assign w_copy_char = ({1'b0, r_pos} < WIN_DEPTH_P) ? r_win[r_pos] : '0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state: a literal handshake may hand straight over to the next token
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_tok_acc) w_next_state = (bus.tok_len != '0) ? COPY : LIT;
      COPY: if (w_out_hs && (r_cnt == r_len - 1'b1)) w_next_state = LIT;
      LIT: begin
        if (w_out_hs) begin
          if (r_char == END_CHAR) w_next_state = DONE;
          else if (w_tok_acc)     w_next_state = (bus.tok_len != '0) ? COPY : LIT;
          else                    w_next_state = IDLE;
        end
      end
      DONE:    w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from registered state; tok_ready never looks at tok_valid
  always_comb begin
    w_tok_ready = 1'b0;
    w_out_valid = 1'b0;
    w_out_char  = '0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: w_tok_ready = 1'b1;
      COPY: begin
        w_out_valid = 1'b1;
        w_out_char  = w_copy_char;
      end
      LIT: begin
        w_out_valid = 1'b1;
        w_out_char  = r_char;
        w_tok_ready = bus.out_ready & (r_char != END_CHAR);
      end
      DONE:    w_finish = 1'b1;
      default: ;
    endcase
  end

  assign bus.tok_ready = w_tok_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_char  = w_out_char;
  assign finish        = w_finish;

  // Token latch and copy counter; a fresh token always restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos  <= '0;
      r_len  <= '0;
      r_char <= '0;
      r_cnt  <= '0;
    end else if (w_tok_acc) begin
      r_pos  <= bus.tok_pos;
      r_len  <= bus.tok_len;
      r_char <= bus.tok_char;
      r_cnt  <= '0;
    end else if (w_out_hs && (r_state == COPY)) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // History window shifts by one on every accepted output character
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN_DEPTH; i++) r_win[i] <= '0;
    end else if (w_out_hs) begin
      r_win[0] <= w_out_char;
      for (int i = 1; i < WIN_DEPTH; i++) r_win[i] <= r_win[i-1];
    end
  end

`ifdef LZ77_POS_CHECK_EN
  logic [POS_W:0] r_fill;
  logic [POS_W:0] w_fill_next;
  logic [POS_W:0] w_pos_ext;
  logic           r_err;

  assign w_pos_ext = {1'b0, bus.tok_pos};

  // Fill count including a character handed off in the same cycle as a token accept
  always_comb begin
    w_fill_next = r_fill;
    if (w_out_hs && (r_fill < WIN_DEPTH_P)) w_fill_next = r_fill + 1'b1;
  end

  // Saturating fill counter and sticky flag for references outside the valid history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill <= '0;
      r_err  <= 1'b0;
    end else begin
      r_fill <= w_fill_next;
      if (w_tok_acc && ((w_pos_ext >= WIN_DEPTH_P) ||
                        ((bus.tok_len != '0) && (w_pos_ext >= w_fill_next))))
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lz77_decoder_stream.sv
// Self-checking bench for lz77_decoder_stream: directed token sequences
// against hand-written character strings, plus random token streams with
// random backpressure checked against a queue-based LZ77 reference model.
module tb_lz77_decoder_stream;

  localparam int          DATA_W    = 8;
  localparam int          WIN_DEPTH = 30;
  localparam int          POS_W     = 5;
  localparam int          LEN_W     = 5;
  localparam logic [7:0]  END_CHAR  = 8'h24;

  logic clk = 1'b0;
  logic reset;
  logic finish;
  logic err;

  lz77_decoder_stream_if #(.DATA_W(DATA_W), .POS_W(POS_W), .LEN_W(LEN_W)) bus();

  lz77_decoder_stream #(
    .DATA_W(DATA_W), .WIN_DEPTH(WIN_DEPTH), .POS_W(POS_W), .LEN_W(LEN_W), .END_CHAR(END_CHAR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .finish(finish),
    .err(err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         tokPos[$];
  int         tokLen[$];
  logic [7:0] tokChar[$];
  logic [7:0] expQ[$];
  logic       expErr;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearTokens();
    tokPos.delete();
    tokLen.delete();
    tokChar.delete();
    expQ.delete();
  endtask

  task automatic addToken(input int p, input int l, input logic [7:0] c);
    tokPos.push_back(p);
    tokLen.push_back(l);
    tokChar.push_back(c);
  endtask

  // Reference decoder: replays tokens over a plain history queue; unfilled or
  // out-of-window positions read as zero, stops after the terminator
  task automatic buildModel();
    logic [7:0] hist[$];
    logic [7:0] ch;
    expQ.delete();
    for (int t = 0; t < tokPos.size(); t++) begin
      for (int k = 0; k < tokLen[t]; k++) begin
        if (tokPos[t] < WIN_DEPTH && tokPos[t] < hist.size()) ch = hist[hist.size() - 1 - tokPos[t]];
        else ch = 8'h00;
        hist.push_back(ch);
        expQ.push_back(ch);
      end
      hist.push_back(tokChar[t]);
      expQ.push_back(tokChar[t]);
      if (tokChar[t] == END_CHAR) break;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset         = 1'b1;
    bus.tok_valid = 1'b0;
    bus.out_ready = 1'b0;
    expErr        = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives the token queue with random valid gaps and random out_ready,
  // checking every handshaked character against expQ
  task automatic applyStimulus(input int readyPct, input int validPct, input int expCycles);
    int         tokIdx = 0;
    int         got = 0;
    int         cycles = 0;
    bit         pending = 0;
    bit         prevStall = 0;
    logic [7:0] prevChar = 8'h00;
    int         fillNow;
    while (got < expQ.size() && cycles < 20000) begin
      @(negedge clk);
      if (!pending && tokIdx < tokPos.size() && $urandom_range(0, 99) < validPct) begin
        pending      = 1'b1;
        bus.tok_pos  = POS_W'(tokPos[tokIdx]);
        bus.tok_len  = LEN_W'(tokLen[tokIdx]);
        bus.tok_char = tokChar[tokIdx];
      end
      bus.tok_valid = pending;
      bus.out_ready = ($urandom_range(0, 99) < readyPct);
      #1;
      if (prevStall) begin
        checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
        checkOutput("holdChar", 32'(bus.out_char), 32'(prevChar));
      end
      if (bus.out_valid && !bus.out_ready) checkOutput("stallTokReady", 32'(bus.tok_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        checkOutput($sformatf("char%0d", got), 32'(bus.out_char), 32'(expQ[got]));
        got++;
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevChar  = bus.out_char;
      if (pending && bus.tok_ready) begin
        fillNow = (got < WIN_DEPTH) ? got : WIN_DEPTH;
        if (tokPos[tokIdx] >= WIN_DEPTH || (tokLen[tokIdx] != 0 && tokPos[tokIdx] >= fillNow))
          expErr = 1'b1;
        tokIdx++;
        pending = 1'b0;
      end
      cycles++;
    end
    checkOutput("allChars", 32'(got), 32'(expQ.size()));
    if (expCycles >= 0) checkOutput("cycles", 32'(cycles), 32'(expCycles));
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.tok_valid = 1'b1;
    bus.tok_pos   = '0;
    bus.tok_len   = '0;
    bus.tok_char  = 8'h41;
    #1;
    if (expQ.size() > 0 && expQ[expQ.size() - 1] == END_CHAR) begin
      checkOutput("finish", 32'(finish), 32'd1);
      checkOutput("doneTokReady", 32'(bus.tok_ready), 32'd0);
      checkOutput("doneOutValid", 32'(bus.out_valid), 32'd0);
    end else begin
      checkOutput("notFinish", 32'(finish), 32'd0);
    end
`ifdef LZ77_POS_CHECK_EN
    checkOutput("err", 32'(err), 32'(expErr));
`else
    checkOutput("err", 32'(err), 32'd0);
`endif
    bus.tok_valid = 1'b0;
  endtask

  initial begin
    int         nTok;
    logic [7:0] rc;
    reset         = 1'b1;
    bus.tok_valid = 1'b0;
    bus.tok_pos   = '0;
    bus.tok_len   = '0;
    bus.tok_char  = '0;
    bus.out_ready = 1'b0;
    expErr        = 1'b0;
    applyReset();
    #1;
    checkOutput("rstTokReady", 32'(bus.tok_ready), 32'd1);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstOutChar", 32'(bus.out_char), 32'd0);
    checkOutput("rstFinish", 32'(finish), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);

    // a, b, then copy of two from position 1: zero-bubble, one char per cycle
    clearTokens();
    addToken(0, 0, 8'h61); addToken(0, 0, 8'h62); addToken(1, 2, 8'h63);
    expQ = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h63};
    applyStimulus(100, 100, 6);

    // Overlapping copy replicates the single preceding character
    applyReset();
    clearTokens();
    addToken(0, 0, 8'h78); addToken(0, 4, 8'h79);
    expQ = '{8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h79};
    applyStimulus(100, 100, 7);

    // Longer overlapping copy under heavy backpressure
    applyReset();
    clearTokens();
    addToken(0, 0, 8'h61); addToken(0, 0, 8'h62); addToken(1, 6, 8'h63);
    expQ = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h62, 8'h63};
    applyStimulus(35, 100, -1);

    // Terminator then reset releases DONE
    applyReset();
    clearTokens();
    addToken(0, 0, 8'h61); addToken(0, 0, END_CHAR);
    expQ = '{8'h61, END_CHAR};
    applyStimulus(100, 100, 3);
    applyReset();
    #1;
    checkOutput("finishCleared", 32'(finish), 32'd0);
    checkOutput("tokReadyAfterDone", 32'(bus.tok_ready), 32'd1);

    // Out-of-window position yields zero for the copy char
    applyReset();
    clearTokens();
    addToken(31, 1, 8'h71);
    expQ = '{8'h00, 8'h71};
    applyStimulus(100, 100, 3);

    // Reset in the middle of a long copy flushes the window
    applyReset();
    @(negedge clk);
    bus.tok_valid = 1'b1; bus.tok_pos = 5'd0; bus.tok_len = 5'd0; bus.tok_char = 8'h61;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("midTokReady", 32'(bus.tok_ready), 32'd1);
    @(negedge clk);
    bus.tok_pos = 5'd0; bus.tok_len = 5'd10; bus.tok_char = 8'h62;
    #1;
    checkOutput("midLit", 32'(bus.out_char), 32'h61);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.tok_valid = 1'b0;
      #1;
      checkOutput($sformatf("midCopy%0d", i), 32'(bus.out_char), 32'h61);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expErr = 1'b0;
    #1;
    checkOutput("postRstTokReady", 32'(bus.tok_ready), 32'd1);
    checkOutput("postRstOutValid", 32'(bus.out_valid), 32'd0);
    clearTokens();
    addToken(3, 1, 8'h7a);
    expQ = '{8'h00, 8'h7a};
    applyStimulus(100, 100, 3);

    // Random token streams against the reference model
    for (int run = 0; run < 16; run++) begin
      applyReset();
      clearTokens();
      nTok = $urandom_range(3, 12);
      for (int t = 0; t < nTok; t++) begin
        do rc = 8'($urandom_range(0, 255)); while (rc == END_CHAR);
        if (t == nTok - 1 && $urandom_range(0, 1) == 1) rc = END_CHAR;
        addToken($urandom_range(0, 31),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6), rc);
      end
      buildModel();
      applyStimulus($urandom_range(30, 100), $urandom_range(30, 100), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lz77_decoder_stream.md
Name: lz77_decoder_stream

Overview:
Parametrised streaming LZ77 decoder. Consumes (position, length, literal) tokens over a valid/ready handshake and emits decoded characters one per cycle over a second valid/ready handshake. Keeps a shift-register sliding window of the last WIN_DEPTH emitted characters. Sits between the token source (memory or bus unpacker) and the character sink, and tolerates backpressure on both sides.

Parameters:
DATA_W, 8, character width in bits
WIN_DEPTH, 30, sliding-window depth in characters; must be at least 2
POS_W, 5, token position width; must satisfy 2^POS_W >= WIN_DEPTH
LEN_W, 5, token length width; maximum copy length is 2^LEN_W-1
END_CHAR, 8'h24, terminating literal ('$')

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
tok_valid  in  1  token present
tok_ready  out  1  decoder accepts token this cycle
tok_pos  in  POS_W  window index to copy from; 0 = most recent character
tok_len  in  LEN_W  number of characters to copy before the literal
tok_char  in  DATA_W  literal emitted after the copy
out_valid  out  1  out_char valid
out_ready  in  1  sink accepts out_char
out_char  out  DATA_W  decoded character
finish  out  1  terminator emitted; held until reset
err  out  1  sticky error flag; tied 0 unless LZ77_POS_CHECK_EN

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all window entries 0, counters 0. Outputs: tok_ready=1, out_valid=0, out_char=0, finish=0, err=0. Reset mid-token discards that token and any partially emitted output.
- State machine:
  - IDLE: tok_ready=1, out_valid=0.
  - COPY: out_valid=1, out_char=win[pos_q].
  - LIT: out_valid=1, out_char=char_q.
  - DONE: tok_ready=0, out_valid=0, finish=1.
- Token accept means tok_valid & tok_ready at a rising edge. On accept, latch pos_q, len_q, char_q and clear cnt. Go to COPY if tok_len!=0, else LIT. The first character is visible the cycle after accept.
- Output handshake means out_valid & out_ready at a rising edge. On each handshake, shift the window: win[0] <= out_char and win[i] <= win[i-1]. The oldest entry is dropped.
- COPY: cnt increments on each handshake. After the handshake with cnt==len_q-1, go to LIT. pos_q stays fixed while the window shifts, so overlapping copies (pos_q < len_q) replicate correctly.
- LIT, on handshake:
  - If char_q==END_CHAR, go to DONE.
  - Otherwise, if a token is accepted in the same cycle, go directly to COPY or LIT for the new token (zero-bubble).
  - Otherwise go to IDLE.
- tok_ready = (state==IDLE) | (state==LIT & out_ready & char_q!=END_CHAR). tok_ready is combinational from registered state and out_ready. It never depends on tok_valid.
- If out_ready is low, out_char, out_valid and all state hold unchanged (AXI-style stable-until-accepted).
- A position with pos_q >= WIN_DEPTH outputs 0 for that copy character. It is still counted and shifted into the window.
- Throughput: len+1 characters per token at one per cycle when out_ready=1, with no idle cycle between tokens.
- DONE is left only by reset. In DONE, tok_valid is ignored.

Optional Feature:
Macro LZ77_POS_CHECK_EN.
- When defined: on token accept, err is set (sticky until reset) if tok_pos>=WIN_DEPTH, or if tok_len!=0 and tok_pos >= (number of characters emitted so far, saturating at WIN_DEPTH). A saturating fill counter tracks the characters emitted. Decoding continues unchanged.
- When undefined: no fill counter, and err is tied 0.

Test Plan:
- Reset, then tokens (0,0,'a'),(0,0,'b'),(1,2,'c'), out_ready=1 -> out stream a,b,a,b,c. The first char appears the cycle after accept, with no bubble between tokens.
- Overlap: after 'x', token (0,4,'y') -> x,x,x,x,x,y.
- Backpressure: out_ready low for 3 cycles mid-copy -> out_char/out_valid stable, tok_ready=0, stream content unchanged.
- Terminator: token (0,0,'$') -> '$' emitted, finish=1 from the next cycle, tok_ready=0 and out_valid=0 thereafter despite tok_valid=1; reset clears finish.
- Reset asserted during a len=10 copy after 4 characters -> next cycle tok_ready=1, out_valid=0, window all 0; token (3,1,'z') then outputs 0,z.
- LZ77_POS_CHECK_EN: token (31,1,'q') with WIN_DEPTH=30 -> err=1 sticky, outputs 0,q; a second build without the macro gives err=0 on the same stimulus.
